// File: rtl/jk_drive_seq_if.sv
// Command handshake between a command producer and the JK drive sequencer.
interface jk_drive_seq_if;
  logic       op_valid;
  logic [1:0] op_code;
  logic       op_ready;

  modport master (
    output op_valid,
    output op_code,
    input  op_ready
  );

  modport slave (
    input  op_valid,
    input  op_code,
    output op_ready
  );
endinterface

// File: rtl/jk_drive_seq.sv
// JK drive sequencer: queues {J,K} commands in a small FIFO, drives each one
// onto j/k for HOLD_CYC cycles followed by GAP_CYC idle cycles, and keeps a
// registered model of the downstream JK flip-flop output.
module jk_drive_seq #(
  parameter int DEPTH    = 4,
  parameter int HOLD_CYC = 1,
  parameter int GAP_CYC  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  jk_drive_seq_if.slave          op,
  output logic                   j,
  output logic                   k,
  output logic                   q_exp,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [3:0]    HOLD_LOAD  = 4'(HOLD_CYC - 1);
  localparam bit            HAS_GAP    = (GAP_CYC > 0);
  localparam logic [3:0]    GAP_LOAD   = HAS_GAP ? 4'(GAP_CYC - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [1:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [3:0]    cnt;
  logic [3:0]    cnt_next;
  logic          j_next;
  logic          k_next;
  logic          push;
  logic          pop;

  // Ready only looks at registered occupancy, so a full FIFO never accepts
  // even when the sequencer pops in the same cycle.
  assign op.op_ready = (fifo_count < FULL_COUNT) && !rst;
  assign push        = op.op_valid && op.op_ready;
  assign pop         = (state == IDLE) && (fifo_count != '0);
  assign busy        = (state != IDLE) || (fifo_count != '0);

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= op.op_code;
  end

  // Next state, next j/k and the shared hold/gap down-counter.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    j_next     = j;
    k_next     = k;
    case (state)
      IDLE: begin
        if (pop) begin
          {j_next, k_next} = mem[rd_ptr];
          cnt_next         = HOLD_LOAD;
          state_next       = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt == 4'd0) begin
          j_next = 1'b0;
          k_next = 1'b0;
          if (HAS_GAP) begin
            state_next = GAP;
            cnt_next   = GAP_LOAD;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      GAP: begin
        if (cnt == 4'd0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        j_next     = 1'b0;
        k_next     = 1'b0;
      end
    endcase
  end

  // Sequencer registers; reset abandons any command in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      j     <= 1'b0;
      k     <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      j     <= j_next;
      k     <= k_next;
    end
  end

  // Downstream flip-flop model, driven by the j/k currently on the wires.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_exp <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q_exp <= 1'b0;
        2'b10:   q_exp <= 1'b1;
        2'b11:   q_exp <= ~q_exp;
        default: q_exp <= q_exp;
      endcase
    end
  end

endmodule
